// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag/branch unit: flag bit positions, branch
// condition codes, FSM state encoding and the condition evaluation rule.
package flag_branch_unit_pkg;

    // Bit positions inside the {v,n,z} flag vector
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Width of the flush down-counter (FLUSH_CYCLES is at most 7)
    localparam int CNT_W = 3;

    // Width of the saturating taken-branch counter
    localparam int TAKEN_W = 16;

    // Branch condition codes
    typedef enum logic [2:0] {
        COND_NE  = 3'b000,
        COND_EQ  = 3'b001,
        COND_GT  = 3'b010,
        COND_LT  = 3'b011,
        COND_GTE = 3'b100,
        COND_LTE = 3'b101,
        COND_OV  = 3'b110,
        COND_UNC = 3'b111
    } cond_e;

    // Redirect/flush sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // Decides whether a condition code holds for the given flag values
    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic v,
                                       input logic n,
                                       input logic z);
        logic res;
        res = 1'b0;
        case (cond_e'(cond))
            COND_NE:  res = !z;
            COND_EQ:  res = z;
            COND_GT:  res = !z && !n;
            COND_LT:  res = n;
            COND_GTE: res = z || !n;
            COND_LTE: res = n || z;
            COND_OV:  res = v;
            COND_UNC: res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bus between the pipeline (execute flags, decode branch info, fetch
// redirect) and the flag/branch unit. The master side is the pipeline,
// the slave side is the flag/branch unit.
interface flag_branch_unit_if #(
    parameter int PC_W = 16
);
    logic            alu_v;
    logic            alu_n;
    logic            alu_z;
    logic [2:0]      flag_wr_en;
    logic            stall;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic [2:0]      flags;
    logic [15:0]     taken_cnt;

    modport master (
        output alu_v, alu_n, alu_z, flag_wr_en, stall,
               br_valid, br_cond, br_target,
        input  redirect, redirect_pc, flush, flags, taken_cnt
    );

    modport slave (
        input  alu_v, alu_n, alu_z, flag_wr_en, stall,
               br_valid, br_cond, br_target,
        output redirect, redirect_pc, flush, flags, taken_cnt
    );
endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// branch_cond_eval: purely combinational mapping of a condition code and
// the v/n/z flags to a taken decision. Also usable by decode for static
// prediction, so it is kept as its own module.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       v_i,
    input  logic       n_i,
    input  logic       z_i,
    output logic       taken_o
);

    // Condition evaluation shared with the package helper
    always_comb begin
        taken_o = cond_true(cond_i, v_i, n_i, z_i);
    end

endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: V/N/Z flag register, branch condition check and a
// redirect/flush sequencer driving fetch.
// Build option: define FLAG_FWD_EN to let a branch see flag values being
// written in the same cycle (ALU bypass). Without it the branch sees only
// the registered flags and decode must leave one bubble after a flag setter.
// FLUSH_CYCLES must lie in 1..7.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    flag_branch_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [TAKEN_W-1:0] TAKEN_MAX = '1;

    logic [2:0]         alu_flags;
    logic [2:0]         flags_q, flags_d;
    logic [2:0]         eff_flags;
    logic               cond_taken;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [TAKEN_W-1:0] taken_cnt_q, taken_cnt_d;

    assign alu_flags = {bus.alu_v, bus.alu_n, bus.alu_z};

    // Per-bit flag load: each flag takes its ALU value when enabled and unstalled
    always_comb begin
        flags_d = flags_q;
        if (!bus.stall) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.flag_wr_en[i]) begin
                    flags_d[i] = alu_flags[i];
                end
            end
        end
    end

    // Flags seen by the branch: bypassed ALU values or the register alone
    always_comb begin
        eff_flags = flags_q;
`ifdef FLAG_FWD_EN
        for (int i = 0; i < 3; i++) begin
            if (bus.flag_wr_en[i]) begin
                eff_flags[i] = alu_flags[i];
            end
        end
`endif
    end

    branch_cond_eval u_cond_eval (
        .cond_i  (bus.br_cond),
        .v_i     (eff_flags[FLAG_V]),
        .n_i     (eff_flags[FLAG_N]),
        .z_i     (eff_flags[FLAG_Z]),
        .taken_o (cond_taken)
    );

    // Sequencer next state: capture on a taken branch, then redirect and flush
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        taken_cnt_d = taken_cnt_q;
        if (!bus.stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.br_valid && cond_taken) begin
                        pc_d    = bus.br_target;
                        state_d = ST_REDIRECT;
                        if (taken_cnt_q != TAKEN_MAX) begin
                            taken_cnt_d = taken_cnt_q + 1'b1;
                        end
                    end
                end
                ST_REDIRECT: begin
                    cnt_d   = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Flag register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Sequencer, target and taken counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        bus.redirect    = (state_q == ST_REDIRECT);
        bus.flush       = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
        bus.redirect_pc = pc_q;
        bus.flags       = flags_q;
        bus.taken_cnt   = taken_cnt_q;
    end

endmodule
